// File: rtl/jellyvl_etherneco_packet_tx_arbiter.sv
// ---------------------------------------------------------------------------
// jellyvl_etherneco_packet_tx_arbiter
//
// Purpose:
//   Shares one packet transmitter between NUM requesters using round-robin
//   arbitration. The winner's header parameters are latched and presented to
//   the transmitter together with a start request. The winner's payload
//   stream is routed into the transmitter, and the transmitter's output
//   stream is watched for end of packet. A programmable watchdog cancels a
//   packet that stops making progress.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   param_timeout         stall limit in cycles (0 disables the watchdog)
//   s_req/_length/_type/_node
//                         per-requester level request and header fields
//   s_grant               one-hot current owner (zero when idle)
//   s_done, s_error       one-cycle end-of-packet pulses (error = cancelled)
//   s_payload_*           per-requester payload streams
//   m_start, m_cancel     transmitter start / cancel controls
//   m_param_*             latched header fields for the transmitter
//   m_tx_start            transmitter acknowledges start
//   m_payload_*           muxed payload stream into the transmitter
//   mon_tx_*              taps on the transmitter output handshake
// ---------------------------------------------------------------------------
module jellyvl_etherneco_packet_tx_arbiter #(
  parameter int NUM           = 2,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,

  input  logic [NUM-1:0]           s_req,
  input  logic [NUM*16-1:0]        s_req_length,
  input  logic [NUM*8-1:0]         s_req_type,
  input  logic [NUM*8-1:0]         s_req_node,
  output logic [NUM-1:0]           s_grant,
  output logic [NUM-1:0]           s_done,
  output logic [NUM-1:0]           s_error,

  input  logic [NUM-1:0]           s_payload_last,
  input  logic [NUM*8-1:0]         s_payload_data,
  input  logic [NUM-1:0]           s_payload_valid,
  output logic [NUM-1:0]           s_payload_ready,

  output logic                     m_start,
  output logic                     m_cancel,
  output logic [15:0]              m_param_length,
  output logic [7:0]               m_param_type,
  output logic [7:0]               m_param_node,
  input  logic                     m_tx_start,

  output logic                     m_payload_last,
  output logic [7:0]               m_payload_data,
  output logic                     m_payload_valid,
  input  logic                     m_payload_ready,

  input  logic                     mon_tx_last,
  input  logic                     mon_tx_valid,
  input  logic                     mon_tx_ready
);

  localparam int PTR_W = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_PAYLOAD,
    ST_WAIT_END,
    ST_DONE,
    ST_CANCEL
  } state_t;

  state_t                   state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         owner;
  logic [TIMEOUT_WIDTH-1:0] wdt;
  logic                     payload_end;

  logic [PTR_W-1:0]         win_idx;
  logic [PTR_W-1:0]         cand;
  logic                     found;
  logic [PTR_W-1:0]         next_ptr;
  logic                     mux_en;
  logic                     pay_beat;
  logic                     mon_beat;
  logic                     timeout_hit;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM);
      if (!found && s_req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    next_ptr = PTR_W'((int'(win_idx) + 1) % NUM);
  end

  // Payload routing. Once the owner's last beat has gone through during
  // START (transmitter FIFO prefill), the path is closed so that a following
  // packet's first beat cannot leak into this one.
  always_comb begin
    mux_en          = ((state == ST_START) || (state == ST_PAYLOAD)) && !payload_end;
    m_payload_valid = 1'b0;
    m_payload_last  = 1'b0;
    m_payload_data  = s_payload_data[int'(owner)*8 +: 8];
    s_payload_ready = '0;
    if (mux_en) begin
      m_payload_valid        = s_payload_valid[owner];
      m_payload_last         = s_payload_last[owner];
      s_payload_ready[owner] = m_payload_ready;
    end
  end

  assign pay_beat    = m_payload_valid && m_payload_ready;
  assign mon_beat    = mon_tx_valid && mon_tx_ready;
  assign timeout_hit = (param_timeout != '0) && (wdt == param_timeout);

  // Main FSM. The watchdog runs every cycle and is forced back to zero on
  // any progress beat; every state transition below also clears it, which
  // overrides the increment because it is the later assignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      wdt            <= '0;
      payload_end    <= 1'b0;
      s_grant        <= '0;
      s_done         <= '0;
      s_error        <= '0;
      m_start        <= 1'b0;
      m_cancel       <= 1'b0;
      m_param_length <= '0;
      m_param_type   <= '0;
      m_param_node   <= '0;
    end else begin
      s_done  <= '0;
      s_error <= '0;

      if (pay_beat || mon_beat) begin
        wdt <= '0;
      end else if (!(&wdt)) begin
        wdt <= wdt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (|s_req) begin
            state          <= ST_START;
            owner          <= win_idx;
            s_grant        <= NUM'(1) << win_idx;
            rr_ptr         <= next_ptr;
            m_start        <= 1'b1;
            m_param_length <= s_req_length[int'(win_idx)*16 +: 16];
            m_param_type   <= s_req_type[int'(win_idx)*8 +: 8];
            m_param_node   <= s_req_node[int'(win_idx)*8 +: 8];
            payload_end    <= 1'b0;
            wdt            <= '0;
          end
        end

        ST_START: begin
          if (timeout_hit) begin
            state    <= ST_CANCEL;
            m_start  <= 1'b0;
            m_cancel <= 1'b1;
            wdt      <= '0;
          end else begin
            if (pay_beat && m_payload_last) begin
              payload_end <= 1'b1;
            end
            if (m_tx_start) begin
              state   <= ST_PAYLOAD;
              m_start <= 1'b0;
              wdt     <= '0;
            end
          end
        end

        // payload_end covers a packet whose whole payload was prefilled
        ST_PAYLOAD: begin
          if (timeout_hit) begin
            state    <= ST_CANCEL;
            m_cancel <= 1'b1;
            wdt      <= '0;
          end else if ((pay_beat && m_payload_last) || payload_end) begin
            state <= ST_WAIT_END;
            wdt   <= '0;
          end
        end

        ST_WAIT_END: begin
          if (timeout_hit) begin
            state    <= ST_CANCEL;
            m_cancel <= 1'b1;
            wdt      <= '0;
          end else if (mon_beat && mon_tx_last) begin
            state  <= ST_DONE;
            s_done <= s_grant;
            wdt    <= '0;
          end
        end

        ST_CANCEL: begin
          state    <= ST_DONE;
          m_cancel <= 1'b0;
          s_done   <= s_grant;
          s_error  <= s_grant;
          wdt      <= '0;
        end

        ST_DONE: begin
          state   <= ST_IDLE;
          s_grant <= '0;
          wdt     <= '0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jellyvl_etherneco_packet_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jellyvl_etherneco_packet_tx_arbiter
//
// Directed bench for the two-requester packet transmit arbiter. The bench
// plays the role of both requesters and of the transmitter (start
// acknowledge, payload ready, output-stream monitor taps).
// ---------------------------------------------------------------------------
module tb_jellyvl_etherneco_packet_tx_arbiter;

  localparam int NUM = 2;
  localparam int TW  = 16;

  logic              clk;
  logic              rst;
  logic [TW-1:0]     param_timeout;
  logic [NUM-1:0]    s_req;
  logic [NUM*16-1:0] s_req_length;
  logic [NUM*8-1:0]  s_req_type;
  logic [NUM*8-1:0]  s_req_node;
  logic [NUM-1:0]    s_grant;
  logic [NUM-1:0]    s_done;
  logic [NUM-1:0]    s_error;
  logic [NUM-1:0]    s_payload_last;
  logic [NUM*8-1:0]  s_payload_data;
  logic [NUM-1:0]    s_payload_valid;
  logic [NUM-1:0]    s_payload_ready;
  logic              m_start;
  logic              m_cancel;
  logic [15:0]       m_param_length;
  logic [7:0]        m_param_type;
  logic [7:0]        m_param_node;
  logic              m_tx_start;
  logic              m_payload_last;
  logic [7:0]        m_payload_data;
  logic              m_payload_valid;
  logic              m_payload_ready;
  logic              mon_tx_last;
  logic              mon_tx_valid;
  logic              mon_tx_ready;

  int vectors;
  int miscompares;
  int expOwner;
  int cancelDelay;

  jellyvl_etherneco_packet_tx_arbiter #(
    .NUM           (NUM),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .param_timeout   (param_timeout),
    .s_req           (s_req),
    .s_req_length    (s_req_length),
    .s_req_type      (s_req_type),
    .s_req_node      (s_req_node),
    .s_grant         (s_grant),
    .s_done          (s_done),
    .s_error         (s_error),
    .s_payload_last  (s_payload_last),
    .s_payload_data  (s_payload_data),
    .s_payload_valid (s_payload_valid),
    .s_payload_ready (s_payload_ready),
    .m_start         (m_start),
    .m_cancel        (m_cancel),
    .m_param_length  (m_param_length),
    .m_param_type    (m_param_type),
    .m_param_node    (m_param_node),
    .m_tx_start      (m_tx_start),
    .m_payload_last  (m_payload_last),
    .m_payload_data  (m_payload_data),
    .m_payload_valid (m_payload_valid),
    .m_payload_ready (m_payload_ready),
    .mon_tx_last     (mon_tx_last),
    .mon_tx_valid    (mon_tx_valid),
    .mon_tx_ready    (mon_tx_ready)
  );

  // 100 MHz-style free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait is never satisfied
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one requester's payload lane
  task automatic applyStimulus(input int idx, input logic valid, input logic last,
                               input logic [7:0] data);
    s_payload_valid[idx]        = valid;
    s_payload_last[idx]         = last;
    s_payload_data[idx*8 +: 8]  = data;
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    cancelDelay     = 0;
    expOwner        = 0;
    rst             = 1'b1;
    param_timeout   = '0;
    s_req           = '0;
    s_req_length    = {16'd7, 16'd3};
    s_req_type      = {8'hB1, 8'hA0};
    s_req_node      = {8'h22, 8'h11};
    s_payload_last  = '0;
    s_payload_data  = '0;
    s_payload_valid = '0;
    m_tx_start      = 1'b0;
    m_payload_ready = 1'b0;
    mon_tx_last     = 1'b0;
    mon_tx_valid    = 1'b0;
    mon_tx_ready    = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    checkOutput("rst_grant", s_grant, 0);
    checkOutput("rst_done", s_done, 0);
    checkOutput("rst_error", s_error, 0);
    checkOutput("rst_start", m_start, 0);
    checkOutput("rst_cancel", m_cancel, 0);
    checkOutput("rst_length", m_param_length, 0);
    checkOutput("rst_pvalid", m_payload_valid, 0);
    checkOutput("rst_pready", s_payload_ready, 0);
    rst = 1'b0;
    tick();

    // ---- single requester, 4-byte payload, watchdog off ----
    s_req = 2'b01;
    tick();
    checkOutput("t1_grant", s_grant, 2'b01);
    checkOutput("t1_start", m_start, 1);
    checkOutput("t1_length", m_param_length, 3);
    checkOutput("t1_type", m_param_type, 8'hA0);
    checkOutput("t1_node", m_param_node, 8'h11);
    m_payload_ready = 1'b1;
    #1;
    checkOutput("t1_start_ready", s_payload_ready, 2'b01);
    m_tx_start = 1'b1;
    tick();
    m_tx_start = 1'b0;
    checkOutput("t1_start_drop", m_start, 0);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(0, 1'b1, (b == 3), 8'hA0 + 8'(b));
      #1;
      checkOutput("t1_beat_valid", m_payload_valid, 1);
      checkOutput("t1_beat_data", m_payload_data, 8'hA0 + b);
      checkOutput("t1_beat_last", m_payload_last, (b == 3) ? 1 : 0);
      tick();
    end
    // WAIT_END: a stray beat offered by the owner must not pass
    applyStimulus(0, 1'b1, 1'b0, 8'hFF);
    #1;
    checkOutput("t1_wait_valid", m_payload_valid, 0);
    checkOutput("t1_wait_ready", s_payload_ready, 0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00);
    mon_tx_valid = 1'b1;
    mon_tx_ready = 1'b1;
    tick();
    tick();
    checkOutput("t1_not_done", s_done, 0);
    mon_tx_last = 1'b1;
    tick();
    mon_tx_valid = 1'b0;
    mon_tx_ready = 1'b0;
    mon_tx_last  = 1'b0;
    s_req        = 2'b00;
    checkOutput("t1_done", s_done, 2'b01);
    checkOutput("t1_no_error", s_error, 0);
    tick();
    checkOutput("t1_done_clear", s_done, 0);
    checkOutput("t1_grant_clear", s_grant, 0);

    // ---- stall: requester 1, timeout 20, only 2 of 8 beats sent ----
    param_timeout = 16'd20;
    s_req = 2'b10;
    tick();
    checkOutput("st_grant", s_grant, 2'b10);
    checkOutput("st_length", m_param_length, 7);
    m_tx_start = 1'b1;
    tick();
    m_tx_start = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 8'h51);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 8'h52);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 8'h00);
    cancelDelay = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (m_cancel) begin
        cancelDelay = k;
        break;
      end
    end
    checkOutput("st_cancel_delay", cancelDelay, 21);
    tick();
    checkOutput("st_cancel_pulse", m_cancel, 0);
    checkOutput("st_done", s_done, 2'b10);
    checkOutput("st_error", s_error, 2'b10);
    s_req = 2'b00;
    tick();
    checkOutput("st_done_clear", s_done, 0);
    checkOutput("st_error_clear", s_error, 0);

    // ---- alternation with both requesters held high; packet 0 prefilled ----
    s_req_length = {16'd1, 16'd1};
    s_req = 2'b11;
    tick();
    for (int p = 0; p < 4; p++) begin
      expOwner = p % 2;
      checkOutput("alt_grant", s_grant, 1 << expOwner);
      checkOutput("alt_type", m_param_type, (expOwner == 1) ? 8'hB1 : 8'hA0);
      applyStimulus(expOwner, 1'b1, 1'b0, 8'h40 + 8'(p * 2));
      applyStimulus(1 - expOwner, 1'b1, 1'b0, 8'hEE);
      #1;
      checkOutput("alt_pre_ready", s_payload_ready, 1 << expOwner);
      checkOutput("alt_pre_data", m_payload_data, 8'h40 + p * 2);
      tick();
      if (p == 0) begin
        applyStimulus(expOwner, 1'b1, 1'b1, 8'h41);
        #1;
        checkOutput("alt_pre_start", m_start, 1);
        checkOutput("alt_pre_ready2", s_payload_ready, 1 << expOwner);
        tick();
        applyStimulus(expOwner, 1'b0, 1'b0, 8'h00);
        m_tx_start = 1'b1;
        tick();
        m_tx_start = 1'b0;
        checkOutput("alt_start_drop", m_start, 0);
        tick();
      end else begin
        applyStimulus(expOwner, 1'b0, 1'b0, 8'h00);
        m_tx_start = 1'b1;
        tick();
        m_tx_start = 1'b0;
        checkOutput("alt_start_drop", m_start, 0);
        applyStimulus(expOwner, 1'b1, 1'b1, 8'h41 + 8'(p * 2));
        tick();
        applyStimulus(expOwner, 1'b0, 1'b0, 8'h00);
      end
      applyStimulus(1 - expOwner, 1'b0, 1'b0, 8'h00);
      checkOutput("alt_wait_ready", s_payload_ready, 0);
      mon_tx_valid = 1'b1;
      mon_tx_ready = 1'b1;
      mon_tx_last  = 1'b1;
      tick();
      mon_tx_valid = 1'b0;
      mon_tx_ready = 1'b0;
      mon_tx_last  = 1'b0;
      checkOutput("alt_done", s_done, 1 << expOwner);
      if (p == 3) s_req = 2'b00;
      tick();
      checkOutput("alt_gap1", s_grant, 0);
      tick();
      checkOutput("alt_gap2", s_grant, (p == 3) ? 0 : (1 << (1 - expOwner)));
    end

    // ---- asynchronous reset mid-packet ----
    s_req = 2'b01;
    tick();
    checkOutput("rs_grant", s_grant, 2'b01);
    m_tx_start = 1'b1;
    tick();
    m_tx_start = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 8'h77);
    #1;
    checkOutput("rs_pvalid_before", m_payload_valid, 1);
    tick();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rs_grant_async", s_grant, 0);
    checkOutput("rs_pvalid_async", m_payload_valid, 0);
    checkOutput("rs_pready_async", s_payload_ready, 0);
    checkOutput("rs_type_async", m_param_type, 0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00);
    s_req = 2'b11;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checkOutput("rs_first_grant", s_grant, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
